// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiply scheduler.
package booth_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Radix-4 Booth digit encodings
    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_e;

    // Map a 3-bit multiplier window {b[2k+1], b[2k], b[2k-1]} to its digit
    function automatic digit_e booth_digit(input logic [2:0] win);
        digit_e d;
        case (win)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Combinational radix-4 Booth partial-product generator.
// Produces digit(win) * a, sign-extended to 2*WIDTH and shifted left by 2k.
module booth_r4_pp
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned KW    = $clog2(WIDTH / 2)
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [2:0]         win,
    input  logic [KW-1:0]      k,
    output logic [2*WIDTH-1:0] pp
);

    logic [WIDTH+1:0]   a_ext;
    logic [WIDTH+1:0]   mag;
    logic [2*WIDTH-1:0] mag_ext;

    // Two guard bits keep -2 * (most negative a) exact before widening
    always_comb begin
        a_ext = {{2{a[WIDTH-1]}}, a};
        mag   = '0;
        case (booth_digit(win))
            POS1:    mag = a_ext;
            POS2:    mag = a_ext << 1;
            NEG1:    mag = -a_ext;
            NEG2:    mag = -(a_ext << 1);
            default: mag = '0;
        endcase
        mag_ext = {{(WIDTH - 2){mag[WIDTH+1]}}, mag};
        pp      = mag_ext << {k, 1'b0};
    end

endmodule

// File: rtl/booth_mul_scheduler.sv
// Round-robin scheduler sharing one iterative radix-4 Booth multiplier
// between NREQ requesters; results are tagged with the requester ID.
module booth_mul_scheduler
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*WIDTH-1:0]      res_p,
    output logic [IDW-1:0]          res_id,
    output logic                    busy
);

    localparam int unsigned KW = $clog2(WIDTH / 2);
    localparam logic [KW-1:0] LAST_K = KW'(WIDTH / 2 - 1);
    localparam logic [IDW:0]  NREQ_W = (IDW + 1)'(NREQ);

    state_e               state_q,  state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]     a_q,      a_d;
    logic [WIDTH-1:0]     b_q,      b_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [KW-1:0]        count_q,  count_d;
    logic [2*WIDTH-1:0]   res_p_q,  res_p_d;
    logic [IDW-1:0]       res_id_q, res_id_d;

    logic [2*NREQ-1:0]    rot_valid;
    logic                 found;
    logic [IDW:0]         cand;
    logic [IDW-1:0]       grant;
    logic [IDW:0]         grant_inc;
    logic [IDW-1:0]       next_ptr;
    logic [NREQ-1:0]      grant_oh;
    logic [WIDTH-1:0]     a_sel;
    logic [WIDTH-1:0]     b_sel;
    logic [WIDTH:0]       b_sh;
    logic [2:0]           win;
    logic [2*WIDTH-1:0]   pp;

    // Rotated round-robin scan: bit i of rot_valid is requester (rr_ptr+i) mod NREQ
    always_comb begin
        rot_valid = {req_valid, req_valid} >> rr_ptr_q;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot_valid[i]) begin
                found = 1'b1;
                cand  = {1'b0, rr_ptr_q} + (IDW + 1)'(i);
            end
        end
        grant     = (cand >= NREQ_W) ? IDW'(cand - NREQ_W) : IDW'(cand);
        grant_inc = {1'b0, grant} + 1'b1;
        next_ptr  = (grant_inc == NREQ_W) ? '0 : IDW'(grant_inc);
        grant_oh  = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (found && grant == IDW'(i)) begin
                grant_oh[i] = 1'b1;
                a_sel       = req_a[i*WIDTH +: WIDTH];
                b_sel       = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Booth window for the current digit, with an implicit zero below bit 0
    always_comb begin
        b_sh = {b_q, 1'b0} >> {count_q, 1'b0};
        win  = b_sh[2:0];
    end

    booth_r4_pp #(
        .WIDTH(WIDTH),
        .KW   (KW)
    ) u_pp (
        .a  (a_q),
        .win(win),
        .k  (count_q),
        .pp (pp)
    );

    // FSM next-state, datapath updates and accept strobe
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        count_d   = count_q;
        res_p_d   = res_p_q;
        res_id_d  = res_id_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (found && !reset) begin
                    req_ready = grant_oh;
                    a_d       = a_sel;
                    b_d       = b_sel;
                    acc_d     = '0;
                    count_d   = '0;
                    res_id_d  = grant;
                    rr_ptr_d  = next_ptr;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                acc_d   = acc_q + pp;
                count_d = count_q + 1'b1;
                if (count_q == LAST_K) begin
                    res_p_d = acc_q + pp;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            res_p_q  <= '0;
            res_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            res_p_q  <= res_p_d;
            res_id_q <= res_id_d;
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        res_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        res_p     = res_p_q;
        res_id    = res_id_q;
    end

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Self-checking bench for booth_mul_scheduler: vector table, corner-case
// sequences and a random scoreboard run against a reference multiply.
`timescale 1ns/1ps
module tb_booth_mul_scheduler;

    localparam int W   = 16;
    localparam int N   = 2;
    localparam int IDW = 1;

    logic               clock = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*W-1:0]     req_a;
    logic [N*W-1:0]     req_b;
    logic               res_valid;
    logic               res_ready;
    logic [2*W-1:0]     res_p;
    logic [IDW-1:0]     res_id;
    logic               busy;

    always #5 clock = ~clock;

    booth_mul_scheduler #(
        .WIDTH(W),
        .NREQ (N),
        .IDW  (IDW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_p    (res_p),
        .res_id   (res_id),
        .busy     (busy)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [2*W-1:0] p;
    } exp_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] p;
    } vec_t;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    int grant_hist[$];
    logic [2*W-1:0] res_hist_p[$];
    int res_hist_id[$];
    logic [IDW-1:0] rr_m;
    logic [N-1:0] hs_mask;
    int served[N];
    int results = 0;

    int g_m;
    int idx_m;
    logic [N-1:0] eg_m;
    exp_t e_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sbv;
        sa  = $signed(a);
        sbv = $signed(b);
        return sa * sbv;
    endfunction

    function automatic int exp_grant(input logic [N-1:0] v, input logic [IDW-1:0] rr);
        for (int i = 0; i < N; i++) begin
            if (v[(int'(rr) + i) % N]) return (int'(rr) + i) % N;
        end
        return -1;
    endfunction

    // Monitor: checks grants against a round-robin model, feeds and drains the scoreboard
    always @(negedge clock) begin
        hs_mask = '0;
        if (reset) begin
            rr_m = '0;
        end else begin
            if (req_ready != '0) begin
                g_m  = exp_grant(req_valid, rr_m);
                eg_m = (g_m < 0) ? '0 : (N'(1) << g_m);
                chk("grant", 64'(req_ready), 64'(eg_m));
                if ((req_valid & req_ready) != '0) begin
                    idx_m = 0;
                    for (int i = 0; i < N; i++) if (req_ready[i]) idx_m = i;
                    e_m.id = IDW'(idx_m);
                    e_m.p  = ref_mul(req_a[idx_m*W +: W], req_b[idx_m*W +: W]);
                    sb.push_back(e_m);
                    rr_m = IDW'((idx_m + 1) % N);
                    served[idx_m]++;
                    grant_hist.push_back(idx_m);
                    hs_mask = req_valid & req_ready;
                end
            end
            if (res_valid && res_ready) begin
                res_hist_p.push_back(res_p);
                res_hist_id.push_back(int'(res_id));
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id=%0d p=0x%0h, expected no result", res_id, res_p);
                end else begin
                    e_m = sb.pop_front();
                    chk("res_p", 64'(res_p), 64'(e_m.p));
                    chk("res_id", 64'(res_id), 64'(e_m.id));
                    results++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic drain();
        req_valid = '0;
        res_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (sb.size() == 0 && !busy) break;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_idle", 64'(busy), 64'd0);
        res_ready = 1'b0;
    endtask

    // One isolated transaction with latency, constant-product and post-handshake checks
    task automatic run_one(input vec_t v);
        int lat;
        lat = 0;
        req_a[v.id*W +: W] = v.a;
        req_b[v.id*W +: W] = v.b;
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        res_ready = 1'b0;
        @(negedge clock);
        chk("req_ready_same_cycle", 64'(req_ready), 64'(N'(1) << v.id));
        tick();
        req_valid = '0;
        req_a[v.id*W +: W] = W'($urandom);
        req_b[v.id*W +: W] = W'($urandom);
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (res_valid) begin
                lat = e;
                break;
            end
        end
        chk("latency", 64'(lat), 64'(W / 2));
        chk("vec_p", 64'(res_p), 64'(v.p));
        chk("vec_id", 64'(res_id), 64'(v.id));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_cleared", 64'(res_valid), 64'd0);
        chk("busy_after_hs", 64'(busy), 64'd0);
    endtask

    vec_t vt[8];
    int   base;
    bit   pending[N];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 16'h0003, 16'h0005, 32'h0000_000F};
        vt[1] = '{1, 16'h8000, 16'h8000, 32'h4000_0000};
        vt[2] = '{0, 16'h7FFF, 16'h8000, 32'hC000_8000};
        vt[3] = '{1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF};
        vt[4] = '{0, 16'h0000, 16'h8000, 32'h0000_0000};
        vt[5] = '{1, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
        vt[6] = '{0, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
        vt[7] = '{1, 16'h8000, 16'h7FFF, 32'hC000_8000};

        // Reset state, with requests already present
        reset     = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_p", 64'(res_p), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);
        do_reset();

        // Directed vectors
        for (int i = 0; i < 8; i++) run_one(vt[i]);

        // Two simultaneous requesters held valid: grants 0,1,0
        do_reset();
        grant_hist.delete();
        res_hist_p.delete();
        req_a[0*W +: W] = 16'd2;
        req_b[0*W +: W] = 16'd3;
        req_a[1*W +: W] = 16'hFFFC;
        req_b[1*W +: W] = 16'd7;
        req_valid = 2'b11;
        res_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (grant_hist.size() >= 3) break;
        end
        drain();
        chk("rr_count", 64'(grant_hist.size()), 64'd3);
        if (grant_hist.size() >= 3) begin
            chk("rr_grant0", 64'(grant_hist[0]), 64'd0);
            chk("rr_grant1", 64'(grant_hist[1]), 64'd1);
            chk("rr_grant2", 64'(grant_hist[2]), 64'd0);
        end
        if (res_hist_p.size() >= 2) begin
            chk("rr_p0", 64'(res_hist_p[0]), 64'h0000_0006);
            chk("rr_p1", 64'(res_hist_p[1]), 64'hFFFF_FFE4);
        end else begin
            chk("rr_results", 64'(res_hist_p.size()), 64'd2);
        end

        // Hold result in DONE while both requesters wait
        req_valid = 2'b11;
        res_ready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (res_valid) break;
        end
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_sb", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e_m = sb[0];
            for (int c = 0; c < 5; c++) begin
                tick();
                chk("hold_res_valid", 64'(res_valid), 64'd1);
                chk("hold_res_p", 64'(res_p), 64'(e_m.p));
                chk("hold_res_id", 64'(res_id), 64'(e_m.id));
                chk("hold_req_ready", 64'(req_ready), 64'd0);
                chk("hold_busy", 64'(busy), 64'd1);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("hold_release", 64'(res_valid), 64'd0);
        @(negedge clock);
        chk("hold_regrant", 64'(req_ready != '0), 64'd1);
        tick();
        drain();

        // Reset during BUSY at count=3
        do_reset();
        res_hist_p.delete();
        res_hist_id.delete();
        req_a[0*W +: W] = 16'h1234;
        req_b[0*W +: W] = 16'h5678;
        req_valid = 2'b01;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (hs_mask[0]) break;
        end
        req_valid = 2'b10;
        req_a[1*W +: W] = 16'(-1234);
        req_b[1*W +: W] = 16'd567;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        sb.delete();
        tick();
        reset = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (res_hist_p.size() > 0) break;
        end
        req_valid = '0;
        chk("midrst_results", 64'(res_hist_p.size()), 64'd1);
        if (res_hist_p.size() > 0) begin
            chk("midrst_p", 64'(res_hist_p[0]), 64'hFFF5_52E2);
            chk("midrst_id", 64'(res_hist_id[0]), 64'd1);
        end
        drain();

        // Random traffic with result stalls
        do_reset();
        base = results;
        for (int i = 0; i < N; i++) begin
            served[i]  = 0;
            pending[i] = 1'b0;
        end
        for (int c = 0; c < 40000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (hs_mask[i]) pending[i] = 1'b0;
                if (!pending[i] && $urandom_range(9) < 7) begin
                    pending[i] = 1'b1;
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = W'($urandom);
                end
                req_valid[i] = pending[i];
            end
            res_ready = ($urandom_range(3) != 0);
            if (results - base >= 1000) break;
        end
        chk("random_done", 64'(results - base >= 1000), 64'd1);
        drain();
        for (int i = 0; i < N; i++) chk("no_starve", 64'(served[i] >= 100), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
